// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port, with one outstanding transaction at a time.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration;
// when undefined the data port has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // instruction-fetch port
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_W-1:0]     o_if_rdata,
  output logic                  o_if_err,
  // data port
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_W-1:0]     i_d_addr,
  input  logic [DATA_W-1:0]     i_d_wdata,
  input  logic [DATA_W/8-1:0]   i_d_be,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_W-1:0]     o_d_rdata,
  output logic                  o_d_err,
  // shared memory port
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned TW_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned TW     = (TW_RAW > 8) ? TW_RAW : 8;

  // owner encoding: 0 = fetch, 1 = data
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                if_err_q, if_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                win;
  logic                resp_fire;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_data;
`ifdef MEM_ARBITER_RR_EN
  logic                last_q, last_d;
`endif

  // Arbitration winner among currently presented requests
  always_comb begin
    win = OWN_IF;
`ifdef MEM_ARBITER_RR_EN
    if (i_if_req && i_d_req) win = ~last_q;
    else                     win = i_d_req;
`else
    win = i_d_req;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    tcnt_d      = tcnt_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;
`ifdef MEM_ARBITER_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_if_req || i_d_req) begin
          owner_d = win;
          state_d = S_REQ;
          if (win == OWN_D) begin
            addr_d  = i_d_addr;
            we_d    = i_d_we;
            wdata_d = i_d_wdata;
            be_d    = i_d_be;
          end else begin
            addr_d  = i_if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          state_d = S_RESP;
          tcnt_d  = '0;
`ifdef MEM_ARBITER_RR_EN
          last_d  = owner_q;
`endif
        end
      end
      S_RESP: begin
        // a real response beats a coincident timeout
        if (i_mem_rvalid) begin
          state_d   = S_IDLE;
          resp_fire = 1'b1;
          resp_data = i_mem_rdata;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_fire) begin
      if (owner_q == OWN_D) begin
        d_rvalid_d = 1'b1;
        d_err_d    = resp_err;
        d_rdata_d  = resp_data;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = resp_err;
        if_rdata_d  = resp_data;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      tcnt_q      <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      tcnt_q      <= tcnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Accept pulses track the memory grant in the same cycle; masked in reset
  assign o_if_gnt = i_rst && (state_q == S_REQ) && i_mem_gnt && (owner_q == OWN_IF);
  assign o_d_gnt  = i_rst && (state_q == S_REQ) && i_mem_gnt && (owner_q == OWN_D);

  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;

  assign o_if_rvalid = if_rvalid_q;
  assign o_if_err    = if_err_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rvalid  = d_rvalid_q;
  assign o_d_err     = d_err_q;
  assign o_d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Build with MEM_ARBITER_RR_EN defined to check the round-robin policy.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  // One full transaction, starting in an IDLE cycle whose requests are driven.
  task automatic do_txn(input string tag, input bit own_d, input logic [31:0] eaddr,
                        input bit ewe, input logic [31:0] ewdata, input logic [3:0] ebe,
                        input int gnt_wait, input int rv_wait,
                        input logic [31:0] rdat, input bit hold);
    cyc(); settle();
    chk({tag, "_mreq"}, 64'(mem_req), 64'd1);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'(eaddr));
    chk({tag, "_mwe"}, 64'(mem_we), 64'(ewe));
    chk({tag, "_mbe"}, 64'(mem_be), 64'(ebe));
    if (ewe) chk({tag, "_mwdata"}, 64'(mem_wdata), 64'(ewdata));
    chk({tag, "_rv_idle"}, 64'({if_rvalid, d_rvalid}), 64'd0);
    for (int i = 0; i < gnt_wait; i++) begin
      chk({tag, "_nogntwait"}, 64'({if_gnt, d_gnt}), 64'd0);
      cyc(); settle();
    end
    mem_gnt = 1'b1;
    settle();
    chk({tag, "_gnt"}, 64'({if_gnt, d_gnt}), own_d ? 64'b01 : 64'b10);
    cyc();
    mem_gnt = 1'b0;
    if (!hold) begin
      if (own_d) d_req = 1'b0;
      else       if_req = 1'b0;
    end
    settle();
    chk({tag, "_gnt_once"}, 64'({if_gnt, d_gnt, mem_req}), 64'd0);
    for (int i = 1; i < rv_wait; i++) begin
      chk({tag, "_norv_wait"}, 64'({if_rvalid, d_rvalid}), 64'd0);
      cyc(); settle();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdat;
    settle();
    chk({tag, "_norv_same"}, 64'({if_rvalid, d_rvalid}), 64'd0);
    cyc();
    mem_rvalid = 1'b0;
    settle();
    chk({tag, "_rvalid"}, 64'({if_rvalid, d_rvalid}), own_d ? 64'b01 : 64'b10);
    chk({tag, "_err"}, 64'({if_err, d_err}), 64'd0);
    if (!ewe) chk({tag, "_rdata"}, own_d ? 64'(d_rdata) : 64'(if_rdata), 64'(rdat));
  endtask

  bit          exp_d [4];
  int          early;

  initial begin
`ifdef MEM_ARBITER_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    cyc(); cyc(); settle();
    chk("rst_if", 64'({if_gnt, if_rvalid, if_err}), 64'd0);
    chk("rst_d", 64'({d_gnt, d_rvalid, d_err}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    chk("rst_mem", 64'({mem_req, mem_we, mem_be}), 64'd0);
    chk("rst_maddr", 64'({mem_addr, mem_wdata}), 64'd0);
    rst = 1'b1;

    // single fetch, grant after 2 cycles, response 3 cycles later
    if_req = 1'b1; if_addr = 32'h100;
    do_txn("fetch", 1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 2, 3, 32'hDEADBEEF, 1'b0);

    // data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
    do_txn("dwrite", 1'b1, 32'h2000, 1'b1, 32'h12345678, 4'b0011, 0, 1, 32'hAAAA5555, 1'b0);

    // fetch only, leaves fetch as last served
    if_req = 1'b1; if_addr = 32'h300;
    do_txn("fetch2", 1'b0, 32'h300, 1'b0, 32'h0, 4'hF, 1, 2, 32'h11112222, 1'b0);

    // both ports requesting continuously for four transactions
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wdata = '0; d_be = 4'hF;
    for (int k = 0; k < 4; k++)
      do_txn($sformatf("both%0d", k), exp_d[k], exp_d[k] ? 32'h500 : 32'h400,
             1'b0, 32'h0, 4'hF, k % 2, 1 + k, 32'hC0DE0000 + 32'(k), 1'b1);
    if_req = 1'b0; d_req = 1'b0;

    // timeout: memory grants but never responds
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_be = 4'hF;
    cyc();
    mem_gnt = 1'b1;
    settle();
    chk("to_gnt", 64'({if_gnt, d_gnt}), 64'b01);
    cyc();
    mem_gnt = 1'b0; d_req = 1'b0;
    settle();
    early = 0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (d_rvalid || if_rvalid || mem_req) early++;
      cyc(); settle();
    end
    chk("to_early", 64'(early), 64'd0);
    chk("to_rvalid", 64'({if_rvalid, d_rvalid}), 64'b01);
    chk("to_err", 64'({if_err, d_err}), 64'b01);
    chk("to_rdata", 64'(d_rdata), 64'd0);
    cyc(); settle();
    chk("to_pulse_end", 64'({d_rvalid, d_err, mem_req}), 64'd0);

    // stray rvalid while IDLE and REQ is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    cyc(); settle();
    chk("stray_idle", 64'({if_rvalid, d_rvalid, mem_req}), 64'd0);
    if_req = 1'b1; if_addr = 32'h700;
    cyc(); settle();
    chk("stray_req1", 64'({if_rvalid, d_rvalid, mem_req}), 64'b001);
    cyc(); settle();
    chk("stray_req2", 64'({if_rvalid, d_rvalid, mem_req}), 64'b001);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    settle();
    chk("stray_gnt", 64'({if_gnt, d_gnt}), 64'b10);
    cyc();
    mem_gnt = 1'b0; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    chk("stray_resp", 64'(mem_req), 64'd0);
    cyc();
    mem_rvalid = 1'b0;
    settle();
    chk("stray_rvalid", 64'({if_rvalid, if_err}), 64'b10);
    chk("stray_rdata", 64'(if_rdata), 64'h77);

    // reset in RESP, late rvalid after release
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    cyc();
    mem_gnt = 1'b1;
    settle();
    chk("rr_gnt", 64'(d_gnt), 64'd1);
    cyc();
    mem_gnt = 1'b0; d_req = 1'b0;
    settle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    settle();
    chk("rr_after", 64'({if_rvalid, d_rvalid, mem_req}), 64'd0);
    chk("rr_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    settle();
    cyc();
    mem_rvalid = 1'b0;
    settle();
    chk("rr_late", 64'({if_rvalid, d_rvalid, mem_req}), 64'd0);

    // simultaneous request straight after reset
    if_req = 1'b1; if_addr = 32'h900;
    d_req = 1'b1; d_addr = 32'hA00; d_we = 1'b0; d_be = 4'hF;
`ifdef MEM_ARBITER_RR_EN
    do_txn("post_rst", 1'b0, 32'h900, 1'b0, 32'h0, 4'hF, 0, 1, 32'hFEED0001, 1'b0);
`else
    do_txn("post_rst", 1'b1, 32'hA00, 1'b0, 32'h0, 4'hF, 0, 1, 32'hFEED0001, 1'b0);
`endif
    if_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent in RESP before abort.
REQ-004 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_rst  in  1  reset; synchronous and active-low.
REQ-006 i_if_req  in  1  instruction-fetch request; held until o_if_gnt.
REQ-007 i_if_addr  in  ADDR_W  fetch address.
REQ-008 o_if_gnt / o_if_rvalid / o_if_rdata / o_if_err  out  1/1/DATA_W/1  fetch accept pulse, response pulse, read data, error flag.
REQ-009 i_d_req / i_d_we / i_d_addr / i_d_wdata / i_d_be  in  1/1/ADDR_W/DATA_W/DATA_W/8  data-port request, write enable, address, write data, byte enables.
REQ-010 o_d_gnt / o_d_rvalid / o_d_rdata / o_d_err  out  1/1/DATA_W/1  data-port accept pulse, response pulse, read data, error flag.
REQ-011 o_mem_req / o_mem_we / o_mem_addr / o_mem_wdata / o_mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  shared single-port memory request.
REQ-012 i_mem_gnt / i_mem_rvalid / i_mem_rdata  in  1/1/DATA_W  memory accept, response valid, read data.

Function
REQ-013 FSM states IDLE, REQ, RESP; one outstanding memory transaction at any time.
REQ-014 IDLE: if any request is present, the winner is latched into an owner register, its address, we, wdata, and be are registered, and the FSM enters REQ next cycle; otherwise it stays in IDLE.
REQ-015 Fetch requests present o_mem_we=0 and o_mem_be=all ones.
REQ-016 REQ: o_mem_req=1 with registered fields stable; on i_mem_gnt=1 the owner's gnt pulses for exactly that cycle, then the FSM enters RESP.
REQ-017 RESP: on i_mem_rvalid=1 the owner's rvalid pulses for one cycle with rdata=i_mem_rdata (registered, one-cycle latency), then the FSM enters IDLE.
REQ-018 Writes also complete via i_mem_rvalid; o_*_rdata is don't-care for writes.
REQ-019 The non-owner's gnt and rvalid remain 0 throughout the transaction; o_*_rdata holds its last value when not valid.
REQ-020 The owner is fixed from IDLE until the return to IDLE; a requester dropping req in REQ does not cancel the transaction.
REQ-021 i_mem_gnt outside REQ and i_mem_rvalid outside RESP are ignored.
REQ-022 Timeout counter (8-bit minimum, clamped to TIMEOUT width) clears on RESP entry and increments each RESP cycle.
REQ-023 If the timeout counter reaches TIMEOUT with no rvalid: owner rvalid=1, err=1, rdata=0 for one cycle, then IDLE.
REQ-024 rvalid and timeout in the same cycle: rvalid wins, err=0.
REQ-025 Minimum transaction length is 3 cycles (IDLE, REQ with gnt, RESP with rvalid); arbitration is re-evaluated in every IDLE cycle.

Reset
REQ-026 When i_rst=0 at a rising edge:
- state=IDLE; all o_* outputs=0; owner=fetch; last-served=data; timeout counter=0.
REQ-027 Reset asserted mid-transaction abandons it with no gnt or rvalid issued; a late i_mem_rvalid after reset is ignored.

Configuration
REQ-028 Macro MEM_ARBITER_RR_EN selects the arbitration policy.
- Defined: round-robin; on simultaneous requests the port not served last wins; the last-served flag updates at each grant.
- Undefined: fixed priority, data port always wins simultaneous requests; the last-served flag is absent.

Verification
REQ-029 Single fetch, addr 0x100, memory gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> one o_if_gnt pulse, one o_if_rvalid with rdata 0xDEADBEEF, o_if_err=0.
REQ-030 Data write, addr 0x2000, wdata 0x12345678, be 0b0011 -> o_mem_we=1 with those values on o_mem_*, o_d_gnt pulse, o_d_rvalid pulse, fetch port silent.
REQ-031 Both ports request continuously for 4 transactions -> with MEM_ARBITER_RR_EN, grant order data, fetch, data, fetch; without it, data ×4.
REQ-032 Memory never asserts rvalid -> exactly TIMEOUT cycles in RESP, owner rvalid=1, err=1, rdata=0, then IDLE.
REQ-033 Reset pulsed in RESP, then i_mem_rvalid=1 one cycle after release -> no rvalid on either port; FSM in IDLE.
REQ-034 i_mem_rvalid=1 while in IDLE or REQ -> no response pulses and no state change.
